// File: rtl/operand_pkg.sv
// Shared types for the operand encoder: FSM state encoding and operand width.
package operand_pkg;

    localparam int OPERAND_W = 2;

    typedef logic [OPERAND_W-1:0] operand_t;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        LOAD_A,
        ACCUM,
        WAIT_REL,
        REL_DB
    } enc_state_t;

endpackage

// File: rtl/debounce_counter.sv
// Debounce interval counter with synchronous clear, count enable and terminal flag.
// One instance times both the press and the release window.
module debounce_counter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CNT_W'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/operand_encoder.sv
// Operand front-end: debounced enter button loads A, then latches the external adder's sum into B.
// Define OPERAND_ENCODER_SYNC_EN to add 2-flop synchronizers on sw_in, btn_in and clr_in.
module operand_encoder
    import operand_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     sw_in,
    input  logic           btn_in,
    input  logic           clr_in,
    input  logic [1:0]     ab_sum_in,
    output logic [1:0]     a_out,
    output logic [1:0]     b_out,
    output logic           load_pulse,
    output logic           busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    operand_t   sw_s;
    logic       btn_s;
    logic       clr_s;
    enc_state_t state, state_next;
    logic       cnt_clr, cnt_en, cnt_done;

`ifdef OPERAND_ENCODER_SYNC_EN
    operand_t sw_m;
    logic     btn_m, clr_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m  <= '0;
            btn_m <= 1'b0;
            clr_m <= 1'b0;
            sw_s  <= '0;
            btn_s <= 1'b0;
            clr_s <= 1'b0;
        end else begin
            sw_m  <= sw_in;
            btn_m <= btn_in;
            clr_m <= clr_in;
            sw_s  <= sw_m;
            btn_s <= btn_m;
            clr_s <= clr_m;
        end
    end
`else
    assign sw_s  = sw_in;
    assign btn_s = btn_in;
    assign clr_s = clr_in;
`endif

    debounce_counter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .done (cnt_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    cnt_clr    = 1'b1;
                    state_next = PRESS_DB;
                end
            end
            PRESS_DB: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (cnt_done) begin
                    state_next = LOAD_A;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            LOAD_A:   state_next = ACCUM;
            ACCUM:    state_next = WAIT_REL;
            WAIT_REL: begin
                if (!btn_s) begin
                    cnt_clr    = 1'b1;
                    state_next = REL_DB;
                end
            end
            REL_DB: begin
                if (btn_s) begin
                    state_next = WAIT_REL;
                end else if (cnt_done) begin
                    state_next = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    // The adder returns {MSB, LSB} reversed; B is stored as {B1,B0}. Clear overrides accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out      <= '0;
            b_out      <= '0;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            if (state == LOAD_A) begin
                a_out <= sw_s;
            end
            if (clr_s) begin
                b_out <= '0;
            end else if (state == ACCUM) begin
                b_out      <= {ab_sum_in[0], ab_sum_in[1]};
                load_pulse <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_operand_encoder.sv
// Scoreboard bench for operand_encoder: press tasks queue expected {a_out,b_out}; a monitor checks each load_pulse.
module tb_operand_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw_in = 2'b00;
    logic       btn_in = 1'b0;
    logic       clr_in = 1'b0;
    logic [1:0] ab_sum_in;
    logic [1:0] a_out, b_out;
    logic       load_pulse, busy;

    logic [1:0] adder_sum;
    logic [3:0] exp_q[$];
    logic [3:0] exp_ab;
    logic       prev_pulse = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         pulses = 0;
    int         pulses_mark;

    operand_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_in     (sw_in),
        .btn_in    (btn_in),
        .clr_in    (clr_in),
        .ab_sum_in (ab_sum_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .load_pulse(load_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External 2-bit adder: ab_sum_in[1] carries the LSB, [0] the MSB.
    always_comb begin
        adder_sum = a_out + b_out;
        ab_sum_in = {adder_sum[0], adder_sum[1]};
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && load_pulse) begin
            pulses++;
            if (prev_pulse) check("load_pulse_width", 4'd2, 4'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_load_pulse", {3'b0, load_pulse}, 4'h0);
            end else begin
                exp_ab = exp_q.pop_front();
                check("scoreboard_ab", {a_out, b_out}, exp_ab);
            end
        end
        prev_pulse = rst_n & load_pulse;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 100) begin
            cycles(1);
            k++;
        end
        check("idle_timeout", {3'b0, busy}, 4'h0);
    endtask

    task automatic press(input logic [1:0] sw, input int hold, input bit expect_load,
                         input logic [3:0] exp);
        if (expect_load) exp_q.push_back(exp);
        sw_in = sw;
        cycles(1);
        btn_in = 1'b1;
        cycles(hold);
        btn_in = 1'b0;
        cycles(2);
        wait_idle();
        check("sb_drained", 4'(exp_q.size()), 4'h0);
    endtask

    initial begin
        cycles(3);
        check("rst_a_out", {2'b0, a_out}, 4'h0);
        check("rst_b_out", {2'b0, b_out}, 4'h0);
        check("rst_load_pulse", {3'b0, load_pulse}, 4'h0);
        check("rst_busy", {3'b0, busy}, 4'h0);
        rst_n = 1'b1;
        cycles(2);

        // Accumulation sequence, expected {a,b} computed by hand.
        press(2'b01, 12, 1, 4'b01_01);
        press(2'b01, 12, 1, 4'b01_10);
        press(2'b11, 12, 1, 4'b11_01);   // 2 + 3 wraps to 1
        press(2'b10, 12, 1, 4'b10_11);
        press(2'b01, 12, 1, 4'b01_00);   // 3 + 1 wraps to 0

        // Bounce: two 3-cycle blips never complete a 4-cycle debounce.
        pulses_mark = pulses;
        sw_in = 2'b11;
        cycles(1);
        btn_in = 1'b1; cycles(3);
        btn_in = 1'b0; cycles(3);
        btn_in = 1'b1; cycles(3);
        btn_in = 1'b0; cycles(10);
        check("bounce_a_out", {2'b0, a_out}, 4'b0001);
        check("bounce_busy", {3'b0, busy}, 4'h0);
        check("bounce_no_pulse", 4'(pulses - pulses_mark), 4'd0);

        // Long hold yields a single accumulation.
        pulses_mark = pulses;
        press(2'b11, 20, 1, 4'b11_11);
        check("hold_one_pulse", 4'(pulses - pulses_mark), 4'd1);

        // Release glitch: 2 low cycles while held must not re-arm.
        pulses_mark = pulses;
        exp_q.push_back(4'b01_00);
        sw_in = 2'b01;
        cycles(1);
        btn_in = 1'b1; cycles(12);
        btn_in = 1'b0; cycles(2);
        btn_in = 1'b1; cycles(8);
        check("rel_bounce_busy", {3'b0, busy}, 4'h1);
        btn_in = 1'b0;
        cycles(2);
        wait_idle();
        check("rel_bounce_one_pulse", 4'(pulses - pulses_mark), 4'd1);
        check("rel_bounce_drained", 4'(exp_q.size()), 4'h0);

        press(2'b10, 12, 1, 4'b10_10);

        // Clear held across ACCUM: A loads, B stays 0, no strobe.
        pulses_mark = pulses;
        clr_in = 1'b1;
        press(2'b01, 12, 0, 4'h0);
        check("clear_a_out", {2'b0, a_out}, 4'b0001);
        check("clear_b_out", {2'b0, b_out}, 4'b0000);
        check("clear_no_pulse", 4'(pulses - pulses_mark), 4'd0);
        clr_in = 1'b0;
        cycles(3);

        // Reset asserted during ACCUM (first cycle a_out shows the new operand).
        pulses_mark = pulses;
        sw_in = 2'b10;
        cycles(1);
        btn_in = 1'b1;
        begin
            int k = 0;
            @(negedge clk);
            while (a_out !== 2'b10 && k < 40) begin
                @(negedge clk);
                k++;
            end
            check("accum_reach_timeout", {2'b0, a_out}, 4'b0010);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_a_out", {2'b0, a_out}, 4'h0);
        check("midrst_b_out", {2'b0, b_out}, 4'h0);
        check("midrst_load_pulse", {3'b0, load_pulse}, 4'h0);
        check("midrst_busy", {3'b0, busy}, 4'h0);
        btn_in = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        check("postrst_busy", {3'b0, busy}, 4'h0);
        check("postrst_b_out", {2'b0, b_out}, 4'h0);
        check("postrst_no_pulse", 4'(pulses - pulses_mark), 4'd0);

        check("total_pulses", 4'(pulses), 4'd8);
        check("final_drained", 4'(exp_q.size()), 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_encoder.md
# operand_encoder

Front-end for the 2-bit accumulator datapath. It samples the operand switches and the enter push-button, debounces the button, and registers the operand A. It then captures the combinational sum returned by the 2-bit adder/decoder into the B register, and presents A and B to the adder/decoder and the BCD display stage. It is the write side of the operand interface; the adder/decoder is the combinational consumer.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: number of stable cycles needed to accept a press or a release; legal range ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the debounce counter; derived, not overridden.

Ports (name, direction, width, meaning):
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sw_in` in 2: raw operand switches, `{A1,A0}`, asynchronous to `clk`.
- `btn_in` in 1: raw enter button, active-high, bouncy.
- `clr_in` in 1: raw clear button, active-high, level-sensitive.
- `ab_sum_in` in 2: adder output; `[1]` = sum LSB, `[0]` = sum MSB.
- `a_out` out 2: registered operand `{A1,A0}`.
- `b_out` out 2: accumulator register `{B1,B0}`.
- `load_pulse` out 1: one-cycle strobe when `b_out` updates from a sum.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Synchronization:** `sw_in`, `btn_in` and `clr_in` each pass through a 2-flop synchronizer. The synchronized signals are `sw_s`, `btn_s` and `clr_s`.
- **States:** IDLE, PRESS_DB, LOAD_A, ACCUM, WAIT_REL, REL_DB.
- **IDLE:** when `btn_s`=1, clear the counter and go to PRESS_DB.
- **PRESS_DB:** if `btn_s`=0, return to IDLE (bounce rejected). Otherwise increment the counter; when count = `DEBOUNCE_CYCLES-1`, go to LOAD_A.
- **LOAD_A:** `a_out <= sw_s`; go to ACCUM.
- **ACCUM:** `b_out[1] <= ab_sum_in[0]` and `b_out[0] <= ab_sum_in[1]`, which converts the adder bit order to `{B1,B0}`. Assert `load_pulse`. Go to WAIT_REL.
- **WAIT_REL:** when `btn_s`=0, clear the counter and go to REL_DB.
- **REL_DB:** if `btn_s`=1, return to WAIT_REL. When count = `DEBOUNCE_CYCLES-1`, go to IDLE.
- **Arithmetic:** B_next = (A + B) mod 4. The sum is produced externally; wrap-around is implicit (3+1 → 0). This block performs no arithmetic.
- **Clear:** when `clr_s`=1, `b_out <= 0` in any state.
  - In ACCUM, clear wins: `b_out`=0 and `load_pulse`=0.
  - Clear does not change the FSM state or `a_out`.
- **Held button:** produces exactly one accumulation. A new accumulation requires a debounced release first.
- **Switch changes:** changes to `sw_in` while not in LOAD_A have no effect on `a_out`.
- **Reset mid-operation:** all state is cleared asynchronously; there is no partial update of `b_out`.

## Timing
- **Reset values:**
  - `a_out`=2'b00, `b_out`=2'b00, `load_pulse`=0, `busy`=0.
  - FSM is in IDLE; counter and synchronizers are 0.
- **Press latency:** from a `btn_in` rising edge to `a_out` update is 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 cycles. `b_out` and `load_pulse` follow one cycle later.
- **`ab_sum_in` stability:** must be stable one cycle after `a_out` changes. The adder is combinational, so this holds.
- **`load_pulse`:** exactly one cycle wide per accepted press.
- **Clear latency:** 2 cycles from `clr_in` high to `b_out`=0, plus 1 cycle for the register update.

## Configuration
- `OPERAND_ENCODER_SYNC_EN`:
  - **Defined:** 2-flop synchronizers on `sw_in`, `btn_in` and `clr_in`, as described above.
  - **Undefined:** synchronizers are removed and inputs are used directly. Press latency drops by 2 cycles. This mode is for simulation or for inputs that are already synchronous.
- Functional behaviour is otherwise identical in both configurations.

## Structure
- **Shared package `operand_pkg`:**
  - FSM enum `enc_state_t` (IDLE, PRESS_DB, LOAD_A, ACCUM, WAIT_REL, REL_DB).
  - `typedef logic [1:0] operand_t`.
  - Constant `OPERAND_W = 2`.
- **Sub-module `debounce_counter`:** counter with clear, enable and terminal-count flag, parameterized by `DEBOUNCE_CYCLES`. The press and release debounce share one instance.
- Synchronizers stay inline.

## Test plan
- Use `DEBOUNCE_CYCLES`=4 throughout.
- **Reset:** assert `rst_n`=0 mid-ACCUM → all outputs are 0 immediately; after release, `busy`=0.
- **Single press:** `sw_in`=01, clean press, adder model connected → `a_out`=01, then `b_out`=01 and one `load_pulse`. A second press with `sw_in`=01 gives `b_out`=10.
- **Wrap-around:** with `b_out`=10, press with `sw_in`=11 → `b_out`=01. With `b_out`=11, press with `sw_in`=01 → `b_out`=00.
- **Bounce:** pulse `btn_in` high for 3 cycles, low, then high for 3 cycles → no `load_pulse` and `a_out` unchanged. Holding for 20 cycles → exactly one `load_pulse`.
- **Release bounce:** glitch `btn_in` low for 2 cycles while held → stays in WAIT_REL, no second accumulation.
- **Clear vs accumulate:** `clr_in` synchronized high in the same cycle as ACCUM → `b_out`=00, `load_pulse`=0, `a_out` keeps the new value.
